ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 2, words per transfer when req_burst=1 (legal 1..4).
REQ-002 Parameter TIMEOUT, default 255, max XFER cycles per word without ACCESS before abort (8-bit counter).
REQ-003 CLK  in  1  clock; all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 req_ren  in  4  per-requester read request (0,1 = icache 0/1; 2,3 = dcache 0/1).
REQ-006 req_wen  in  4  per-requester write request.
REQ-007 req_burst  in  4  1 = BURST_LEN-word transfer, 0 = single word.
REQ-008 req_addr  in  4x32  per-requester word-aligned base address.
REQ-009 req_store  in  4x32  per-requester write data for the current beat.
REQ-010 req_wait  out  4  per-requester wait; 0 = current beat completes this cycle.
REQ-011 req_load  out  32  read data, broadcast to all requesters, equals ramload combinationally.
REQ-012 grant  out  4  one-hot registered owner of the RAM port; 0 when idle.
REQ-013 ramaddr/ramstore  out  32 each  RAM address and write data.
REQ-014 ramREN/ramWEN  out  1 each  RAM read/write strobes.
REQ-015 ramstate  in  2  ramstate_t from cpu_types_pkg (FREE, BUSY, ACCESS, ERROR).
REQ-016 ramload  in  32  RAM read data.
REQ-017 err_clr  in  1  clears err.  err  out  1  sticky error flag.

Function
REQ-018 States: IDLE, XFER; registered state, grant, beat counter (2 bits), timeout counter (8 bits), last_grant (2 bits), err.
REQ-019 Request pending for requester i = req_ren[i] | req_wen[i]; both set -> treated as write.
REQ-020 IDLE: scan i = last_grant+1, +2, +3, +4 (mod 4); first pending requester is latched into grant, beat=0, timeout=0, -> XFER next cycle; none pending -> stay IDLE.
REQ-021 Grant latency: request sampled in IDLE at cycle N -> grant and RAM strobes valid at cycle N+1; no RAM strobe is driven in IDLE.
REQ-022 XFER: ramaddr = req_addr[g] + 4*beat; ramstore = req_store[g] (0 on reads); ramWEN = req_wen[g]; ramREN = req_ren[g] & ~req_wen[g].
REQ-023 XFER, ramstate==ACCESS: req_wait[g]=0 that cycle (combinational); beat increments, timeout clears; if last beat (beat==BURST_LEN-1 with burst, else beat==0) -> IDLE, last_grant=g, grant=0.
REQ-024 XFER, ramstate==ERROR: req_wait[g]=0 that cycle, err set, -> IDLE, last_grant=g.
REQ-025 XFER, ramstate FREE/BUSY: req_wait[g]=1, timeout increments; at TIMEOUT -> err set, -> IDLE, last_grant=g, req_wait stays 1.
REQ-026 Requester g drops both ren and wen in XFER: strobes deassert that cycle, -> IDLE next cycle, last_grant=g, err unaffected.
REQ-027 Type (read/write) is sampled per cycle from the granted requester; a switch mid-burst is legal and not flagged.
REQ-028 req_wait[i]=1 for every i != g at all times, and for all i in IDLE.
REQ-029 err: set by REQ-024/025; err_clr clears it; set and clear in same cycle -> set wins.
REQ-030 Burst address wrap: beat offset adds without wrap handling; 32-bit overflow rolls modulo 2^32.
REQ-031 No new grant occurs in the cycle the state returns to IDLE; minimum one IDLE cycle between transfers.

Reset
REQ-032 RST asserted (any time, including mid-burst): state=IDLE, grant=0, req_wait=4'b1111, ramREN=ramWEN=0, ramaddr=ramstore=0, beat=0, timeout=0, err=0, last_grant=3 (first scan starts at requester 0).
REQ-033 Mid-burst reset discards the transfer; no completion is reported for it after RST deasserts.

Verification
REQ-034 Reset, then req_ren=4'b0001, addr 0x100, burst=0, ACCESS on first XFER cycle -> grant=0001 at cycle+1, ramaddr=0x100, ramREN=1, req_wait[0]=0 one cycle, req_load=ramload, then IDLE.
REQ-035 All four request simultaneously, single-word, ACCESS immediate -> grant order 0001,0010,0100,1000,0001 with one IDLE cycle between grants.
REQ-036 req_wen[2], burst=1, addr 0x200, BUSY 2 cycles then ACCESS per beat -> ramaddr 0x200 then 0x204, ramWEN=1 throughout, req_wait[2] low exactly twice, last_grant=2.
REQ-037 Granted read, ramstate held BUSY 255 cycles -> err=1, return to IDLE, req_wait stays 1; err_clr -> err=0.
REQ-038 RST pulsed on beat 1 of a 2-word burst -> all outputs at REQ-032 values immediately; next request granted from requester 0 scan.
REQ-039 ERROR returned on beat 0 of requester 3 -> req_wait[3]=0 one cycle, err=1, next scan starts at requester 0.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the four-way RAM port arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the RAM.
interface ram_port_arbiter_if;
  logic [3:0]       req_ren;
  logic [3:0]       req_wen;
  logic [3:0]       req_burst;
  logic [3:0][31:0] req_addr;
  logic [3:0][31:0] req_store;
  logic [3:0]       req_wait;
  logic [31:0]      req_load;
  logic [3:0]       grant;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic             ramREN;
  logic             ramWEN;
  logic [1:0]       ramstate;
  logic [31:0]      ramload;
  logic             err_clr;
  logic             err;

  modport master (
    input  req_ren, req_wen, req_burst, req_addr, req_store, ramstate, ramload, err_clr,
    output req_wait, req_load, grant, ramaddr, ramstore, ramREN, ramWEN, err
  );

  modport slave (
    output req_ren, req_wen, req_burst, req_addr, req_store, ramstate, ramload, err_clr,
    input  req_wait, req_load, grant, ramaddr, ramstore, ramREN, ramWEN, err
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between two icache and two dcache requesters,
// with optional fixed-length bursts, a per-word timeout and a sticky error flag.
module ram_port_arbiter #(
  parameter int BURST_LEN = 2,
  parameter int TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.master bus
);

  localparam logic [1:0] RAM_ACCESS  = 2'd2;
  localparam logic [1:0] RAM_ERROR   = 2'd3;
  localparam logic [1:0] BEAT_LAST   = 2'(BURST_LEN - 1);
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  beat_q, beat_d;
  logic [7:0]  timeout_q, timeout_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic        err_q, err_d;

  logic [1:0]  g_idx;
  logic [1:0]  scan_idx;
  logic [3:0]  pending;
  logic        is_last;
  logic        xfer_done;
  logic [3:0]  wait_c;
  logic [31:0] addr_c;
  logic [31:0] store_c;
  logic        ren_c;
  logic        wen_c;

  assign pending = bus.req_ren | bus.req_wen;

  always_comb begin
    g_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) g_idx = 2'(i);
    end
  end

  assign is_last = bus.req_burst[g_idx] ? (beat_q == BEAT_LAST) : (beat_q == 2'd0);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    beat_d       = beat_q;
    timeout_d    = timeout_q;
    last_grant_d = last_grant_q;
    err_d        = err_q & ~bus.err_clr;
    scan_idx     = 2'd0;
    xfer_done    = 1'b0;
    wait_c       = 4'b1111;
    addr_c       = 32'd0;
    store_c      = 32'd0;
    ren_c        = 1'b0;
    wen_c        = 1'b0;

    case (state_q)
      IDLE: begin
        beat_d    = 2'd0;
        timeout_d = 8'd0;
        grant_d   = 4'b0000;
        // Scan farthest-first so the requester nearest after last_grant wins.
        for (int k = 4; k >= 1; k--) begin
          scan_idx = last_grant_q + 2'(k);
          if (pending[scan_idx]) begin
            grant_d = 4'b0001 << scan_idx;
            state_d = XFER;
          end
        end
      end

      XFER: begin
        addr_c = bus.req_addr[g_idx] + {28'd0, beat_q, 2'b00};
        if (!pending[g_idx]) begin
          xfer_done = 1'b1;
        end else begin
          wen_c   = bus.req_wen[g_idx];
          ren_c   = bus.req_ren[g_idx] & ~bus.req_wen[g_idx];
          store_c = bus.req_wen[g_idx] ? bus.req_store[g_idx] : 32'd0;
          if (bus.ramstate == RAM_ACCESS) begin
            wait_c[g_idx] = 1'b0;
            beat_d        = beat_q + 2'd1;
            timeout_d     = 8'd0;
            xfer_done     = is_last;
          end else if (bus.ramstate == RAM_ERROR) begin
            wait_c[g_idx] = 1'b0;
            err_d         = 1'b1;
            xfer_done     = 1'b1;
          end else begin
            timeout_d = timeout_q + 8'd1;
            if (({1'b0, timeout_q} + 9'd1) >= TIMEOUT_LIM) begin
              err_d     = 1'b1;
              xfer_done = 1'b1;
            end
          end
        end
        if (xfer_done) begin
          state_d      = IDLE;
          grant_d      = 4'b0000;
          last_grant_d = g_idx;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 4'b0000;
      beat_q       <= 2'd0;
      timeout_q    <= 8'd0;
      last_grant_q <= 2'd3;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      beat_q       <= beat_d;
      timeout_q    <= timeout_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.err      = err_q;
  assign bus.req_wait = wait_c;
  assign bus.req_load = bus.ramload;
  assign bus.ramaddr  = addr_c;
  assign bus.ramstore = store_c;
  assign bus.ramREN   = ren_c;
  assign bus.ramWEN   = wen_c;

endmodule
